// File: rtl/fpu_cvt_pkg.sv
// Shared types for the converter arbiter: FSM states,
// default requester count and the round-robin grant search.
package fpu_cvt_pkg;

  localparam int NREQ_DEF = 4;
  localparam int MAXREQ   = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic       any;
    logic [2:0] idx;
  } grant_t;

  // First asserted request at or after ptr, wrapping modulo n.
  function automatic grant_t rr_grant(
    input logic [2:0] ptr,
    input logic [7:0] req,
    input int         n
  );
    grant_t g;
    int     j;
    g = '0;
    for (int k = 0; k < MAXREQ; k++) begin
      j = (int'(ptr) + k) % n;
      if (k < n && !g.any && req[j]) begin
        g.any = 1'b1;
        g.idx = 3'(j);
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/fpu_cvt_arbiter_cvt.sv
// Int_to_Float: signed int32 to IEEE-754 single, truncating.
// Ports: int_in operand; fp_out result; p_lost dropped bits; done_flag.
module Int_to_Float (
  input  logic [31:0] int_in,
  output logic [31:0] fp_out,
  output logic        p_lost,
  output logic        done_flag
);

  logic        sign;
  logic [31:0] mag;
  logic [31:0] norm;
  logic [4:0]  lz;
  logic        found;

  always_comb begin
    sign = int_in[31];
    mag  = sign ? (~int_in + 32'd1) : int_in;
    lz    = '0;
    found = 1'b0;
    for (int i = 31; i >= 0; i--) begin
      if (!found && mag[i]) begin
        lz    = 5'(31 - i);
        found = 1'b1;
      end
    end
    // Leading one lands on bit 31; bits below the mantissa are lost.
    norm = mag << lz;
    if (mag == '0) begin
      fp_out = '0;
      p_lost = 1'b0;
    end else begin
      fp_out = {sign, 8'(8'd158 - {3'b0, lz}), norm[30:8]};
      p_lost = |norm[7:0];
    end
    done_flag = 1'b1;
  end

endmodule

// File: rtl/fpu_cvt_arbiter.sv
// Round-robin arbiter sharing one Int_to_Float among NREQ requesters.
// Ports: clk, rst_n; req_valid/req_data/req_ready; rsp_*; busy.
module fpu_cvt_arbiter
  import fpu_cvt_pkg::*;
#(
  parameter  int NREQ  = NREQ_DEF,
  localparam int TAG_W = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [32*NREQ-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_data,
  output logic [TAG_W-1:0]  rsp_tag,
  output logic              rsp_p_lost,
  output logic              busy
);

  state_t           state;
  state_t           state_n;
  logic [TAG_W-1:0] ptr;
  logic [TAG_W-1:0] ptr_n;
  logic [TAG_W-1:0] tag_reg;
  logic [TAG_W-1:0] sel_tag;
  logic [31:0]      op_reg;
  logic [31:0]      sel_data;
  grant_t           g;
  logic [31:0]      cvt_data;
  logic             cvt_lost;
  logic             cvt_done;

  Int_to_Float u_cvt (
    .int_in    (op_reg),
    .fp_out    (cvt_data),
    .p_lost    (cvt_lost),
    .done_flag (cvt_done)
  );

  always_comb begin
    g = rr_grant(3'(ptr), 8'(req_valid), NREQ);
    sel_data = '0;
    sel_tag  = '0;
    ptr_n    = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (g.idx == 3'(i)) begin
        sel_data = req_data[32*i +: 32];
        sel_tag  = TAG_W'(i);
        ptr_n    = (i == NREQ - 1) ? '0 : TAG_W'(i + 1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (g.any)     state_n = CONV;
      CONV:    if (cvt_done)  state_n = RESP;
      RESP:    if (rsp_ready) state_n = IDLE;
      default:                state_n = IDLE;
    endcase
  end

  // Grant is suppressed while reset is asserted.
  always_comb begin
    req_ready = '0;
    busy      = (state != IDLE);
    if (state == IDLE && rst_n && g.any) begin
      for (int i = 0; i < NREQ; i++)
        req_ready[i] = (g.idx == 3'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr        <= '0;
      op_reg     <= '0;
      tag_reg    <= '0;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      rsp_tag    <= '0;
      rsp_p_lost <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (g.any) begin
          op_reg  <= sel_data;
          tag_reg <= sel_tag;
          ptr     <= ptr_n;
        end
        CONV: if (cvt_done) begin
          rsp_data   <= cvt_data;
          rsp_p_lost <= cvt_lost;
          rsp_tag    <= tag_reg;
          rsp_valid  <= 1'b1;
        end
        RESP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_cvt_arbiter.sv
// Bench for fpu_cvt_arbiter: directed literal checks plus random
// traffic compared every cycle against a transaction-level model.
module tb_fpu_cvt_arbiter;

  localparam int N = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  req_valid = '0;
  logic [32*N-1:0] req_data = '0;
  logic [N-1:0]  req_ready;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [31:0]   rsp_data;
  logic [1:0]    rsp_tag;
  logic          rsp_p_lost;
  logic          busy;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  bit started = 0;

  fpu_cvt_arbiter #(.NREQ(N)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_tag    (rsp_tag),
    .rsp_p_lost (rsp_p_lost),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference conversion by plain integer arithmetic.
  function automatic logic [32:0] model_cvt(input logic [31:0] x);
    longint m, frac;
    int e;
    logic s;
    logic lost;
    if (x == 0) return '0;
    s = x[31];
    m = s ? (64'd1 << 32) - longint'(x) : longint'(x);
    e = 0;
    while ((m >> (e + 1)) != 0) e++;
    frac = (m << 23) >> e;
    lost = ((m << 23) & ((64'd1 << e) - 1)) != 0;
    return {lost, s, 8'(127 + e), 23'(frac - (64'd1 << 23))};
  endfunction

  // Transaction-level model: phase 0 idle, 1 converting, 2 responding.
  int         m_phase = 0;
  int         m_ptr = 0;
  logic [31:0] m_op = 0;
  int         m_tag = 0;
  logic       m_valid = 0;
  logic [31:0] m_data = 0;
  int         m_rtag = 0;
  logic       m_lost = 0;

  always @(negedge clk) begin
    int gi;
    logic [N-1:0] er;
    logic [32:0] c;
    if (started) begin
      gi = -1;
      for (int k = 0; k < N; k++)
        if (gi < 0 && req_valid[(m_ptr + k) % N]) gi = (m_ptr + k) % N;
      er = '0;
      if (m_phase == 0 && rst_n && gi >= 0) er[gi] = 1'b1;
      check("req_ready", 32'(req_ready), 32'(er));
      check("busy", 32'(busy), 32'(m_phase != 0));
      check("rsp_valid", 32'(rsp_valid), 32'(m_valid));
      check("rsp_data", rsp_data, m_data);
      check("rsp_tag", 32'(rsp_tag), 32'(m_rtag));
      check("rsp_p_lost", 32'(rsp_p_lost), 32'(m_lost));
      if (!rst_n) begin
        m_phase = 0; m_ptr = 0; m_valid = 0;
        m_data = 0; m_rtag = 0; m_lost = 0;
      end else if (m_phase == 0) begin
        if (gi >= 0) begin
          m_op = req_data[32*gi +: 32];
          m_tag = gi;
          m_ptr = (gi + 1) % N;
          m_phase = 1;
        end
      end else if (m_phase == 1) begin
        c = model_cvt(m_op);
        m_data = c[31:0];
        m_lost = c[32];
        m_rtag = m_tag;
        m_valid = 1;
        m_phase = 2;
      end else if (rsp_ready) begin
        m_valid = 0;
        m_phase = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 12 && busy; i++) tick();
    #1;
    check("idle_timeout", 32'(busy), 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = '0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic single(input int idx, input logic [31:0] d,
                        input logic [31:0] ed, input logic el);
    req_valid = '0;
    req_valid[idx] = 1'b1;
    req_data[32*idx +: 32] = d;
    rsp_ready = 1'b1;
    #1;
    check("single_grant", 32'(req_ready), 32'(1 << idx));
    tick();
    req_valid = '0;
    tick();
    #1;
    check("single_valid", 32'(rsp_valid), 1);
    check("single_data", rsp_data, ed);
    check("single_tag", 32'(rsp_tag), 32'(idx));
    check("single_lost", 32'(rsp_p_lost), 32'(el));
    tick();
    #1;
    check("single_idle", 32'(busy), 0);
  endtask

  function automatic logic [31:0] rnd_data();
    logic [31:0] v;
    v = $urandom >> $urandom_range(0, 31);
    if ($urandom_range(0, 1) == 1) v = -v;
    if ($urandom_range(0, 15) == 0) v = 32'h8000_0000;
    return v;
  endfunction

  initial begin
    int order[$];
    int acc_cyc[$];
    logic [N-1:0] acc;
    int exp_order[5] = '{0, 1, 2, 3, 0};

    tick();
    tick();
    started = 1;
    #1;
    check("reset_valid", 32'(rsp_valid), 0);
    check("reset_data", rsp_data, 0);
    check("reset_busy", 32'(busy), 0);
    rst_n = 1'b1;
    tick();

    single(2, 32'h0000_0001, 32'h3F80_0000, 1'b0);
    single(0, 32'hFFFF_FFFF, 32'hBF80_0000, 1'b0);
    single(0, 32'h7FFF_FFFF, 32'h4EFF_FFFF, 1'b1);
    single(0, 32'h0000_0000, 32'h0000_0000, 1'b0);
    single(0, 32'h8000_0000, 32'hCF00_0000, 1'b0);

    // Round robin with everyone requesting.
    do_reset();
    for (int i = 0; i < N; i++) req_data[32*i +: 32] = 32'(i * 1000 + 7);
    req_valid = '1;
    for (int c = 0; c < 24 && order.size() < 5; c++) begin
      #1;
      for (int i = 0; i < N; i++) if (req_ready[i]) order.push_back(i);
      tick();
    end
    check("rr_count", 32'(order.size()), 5);
    for (int i = 0; i < 5 && i < order.size(); i++)
      check("rr_order", 32'(order[i]), 32'(exp_order[i]));
    req_valid = '0;
    wait_idle();

    // Backpressure held for five cycles in RESP.
    rsp_ready = 1'b0;
    req_valid = 4'b0010;
    req_data[63:32] = 32'h1234_5678;
    tick();
    req_valid = 4'b0001;
    tick();
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp_valid", 32'(rsp_valid), 1);
      check("bp_data", rsp_data, 32'h4D91_A2B3);
      check("bp_tag", 32'(rsp_tag), 1);
      check("bp_ready", 32'(req_ready), 0);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    #1;
    check("bp_idle", 32'(busy), 0);
    check("bp_cleared", 32'(rsp_valid), 0);
    tick();
    req_valid = '0;
    wait_idle();

    // Reset during CONV; pointer must return to 0.
    req_valid = 4'b0100;
    req_data[95:64] = 32'h0BAD_0BAD;
    tick();
    req_valid = '0;
    rst_n = 1'b0;
    tick();
    check("rst_valid", 32'(rsp_valid), 0);
    check("rst_data", rsp_data, 0);
    check("rst_tag", 32'(rsp_tag), 0);
    check("rst_lost", 32'(rsp_p_lost), 0);
    check("rst_busy", 32'(busy), 0);
    rst_n = 1'b1;
    req_valid = 4'b1010;
    req_data[63:32] = 32'h0000_0010;
    req_data[127:96] = 32'h0000_0055;
    #1;
    check("rst_ptr_grant", 32'(req_ready), 32'b0010);
    tick();
    req_valid = 4'b1000;
    tick();
    #1;
    check("rst_next_data", rsp_data, 32'h4180_0000);
    check("rst_next_tag", 32'(rsp_tag), 1);
    req_valid = '0;
    wait_idle();

    // Back-to-back from requester 3.
    req_valid = 4'b1000;
    req_data[127:96] = rnd_data();
    for (int c = 0; c < 16; c++) begin
      #1;
      if (req_ready[3]) acc_cyc.push_back(cyc);
      tick();
      if (acc_cyc.size() > 0 && acc_cyc[$] == cyc - 1)
        req_data[127:96] = rnd_data();
    end
    req_valid = '0;
    check("b2b_count", 32'(acc_cyc.size() >= 5), 1);
    for (int i = 1; i < acc_cyc.size(); i++)
      check("b2b_interval", 32'(acc_cyc[i] - acc_cyc[i-1]), 3);
    wait_idle();

    // Random traffic.
    acc = '0;
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] || acc[i]) begin
          req_valid[i] = ($urandom_range(0, 2) != 0);
          req_data[32*i +: 32] = rnd_data();
        end else if ($urandom_range(0, 9) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      rst_n = ($urandom_range(0, 99) != 0);
      #1;
      acc = req_valid & req_ready;
      tick();
    end
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    req_valid = '0;
    wait_idle();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
